// File: rtl/fifo_arbiter_if.sv
// fifo_arbiter_if: requester ports and FIFO command/status bundle for fifo_arbiter
interface fifo_arbiter_if #(parameter int DATA_WIDTH = 32);
    logic                  req_a;
    logic                  req_b;
    logic                  wr_a;
    logic                  wr_b;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] din_b;
    logic                  ack_a;
    logic                  ack_b;
    logic                  err_a;
    logic                  err_b;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;
    logic [1:0]            fifo_opcode;
    logic [DATA_WIDTH-1:0] fifo_din;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport master (
        output req_a, req_b, wr_a, wr_b, din_a, din_b, fifo_dout, fifo_full, fifo_empty,
        input  ack_a, ack_b, err_a, err_b, rd_data, busy, fifo_opcode, fifo_din
    );

    modport slave (
        input  req_a, req_b, wr_a, wr_b, din_a, din_b, fifo_dout, fifo_full, fifo_empty,
        output ack_a, ack_b, err_a, err_b, rd_data, busy, fifo_opcode, fifo_din
    );
endinterface

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin two-port arbiter issuing single FIFO read/write commands
module fifo_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input logic           clk,
    input logic           rst_n,
    fifo_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

    state_e                state_q, state_d;
    logic                  last_b_q, last_b_d;
    logic                  win_b_q, win_b_d;
    logic                  wr_q, wr_d;
    logic                  err_q, err_d;
    logic [1:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] fifo_din_q, fifo_din_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic                  err_a_q, err_a_d, err_b_q, err_b_d;
    logic                  busy_q, busy_d;

    logic                  any_req, win_b, sel_wr, accept, grant;
    logic [DATA_WIDTH-1:0] sel_din;

    // B wins when alone, or when both request and A was granted last
    assign any_req = bus.req_a | bus.req_b;
    assign win_b   = bus.req_b & (~bus.req_a | ~last_b_q);
    assign sel_wr  = win_b ? bus.wr_b : bus.wr_a;
    assign sel_din = win_b ? bus.din_b : bus.din_a;
    assign accept  = sel_wr ? ~bus.fifo_full : ~bus.fifo_empty;
    assign grant   = (state_q == IDLE) & any_req;

    // State register plus all registered outputs and latched transaction fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_b_q   <= 1'b1;
            win_b_q    <= 1'b0;
            wr_q       <= 1'b0;
            err_q      <= 1'b0;
            opcode_q   <= 2'b00;
            fifo_din_q <= '0;
            rd_data_q  <= '0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            win_b_q    <= win_b_d;
            wr_q       <= wr_d;
            err_q      <= err_d;
            opcode_q   <= opcode_d;
            fifo_din_q <= fifo_din_d;
            rd_data_q  <= rd_data_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            busy_q     <= busy_d;
        end
    end

    // Next state: accepted grants pass through ISSUE, rejected ones go straight to DONE
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = !any_req ? IDLE : (accept ? ISSUE : DONE);
            ISSUE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it
    always_comb begin
        last_b_d   = grant ? win_b : last_b_q;
        win_b_d    = grant ? win_b : win_b_q;
        wr_d       = grant ? sel_wr : wr_q;
        err_d      = grant ? ~accept : err_q;
        opcode_d   = (grant && accept) ? (sel_wr ? 2'b01 : 2'b10) : 2'b00;
        fifo_din_d = (grant && accept) ? sel_din : fifo_din_q;
        rd_data_d  = (state_q == ISSUE && !wr_q) ? bus.fifo_dout : rd_data_q;
        ack_a_d    = (state_d == DONE) && !win_b_d;
        ack_b_d    = (state_d == DONE) && win_b_d;
        err_a_d    = ack_a_d && err_d;
        err_b_d    = ack_b_d && err_d;
        busy_d     = (state_d != IDLE);
    end

    assign bus.ack_a       = ack_a_q;
    assign bus.ack_b       = ack_b_q;
    assign bus.err_a       = err_a_q;
    assign bus.err_b       = err_b_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.busy        = busy_q;
    assign bus.fifo_opcode = opcode_q;
    assign bus.fifo_din    = fifo_din_q;
endmodule

// File: tb/tb_fifo_arbiter.sv
// tb_fifo_arbiter: scoreboard bench with a transaction-level arbiter/FIFO reference model
module tb_fifo_arbiter;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        bit          port_b;
        bit          err;
        bit          rd;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] din;
        bit          chk_din;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total = 0;
    int   cyc = 0;

    resp_t       resp_q[$];
    op_t         op_q[$];
    logic [31:0] env_q[$];
    logic [31:0] model_q[$];
    bit          model_last_b = 1'b1;
    resp_t       mr;
    op_t         mo;

    always #5 clk = ~clk;

    fifo_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Behavioural FIFO seen by the DUT: registered head, full and empty
    always @(posedge clk) begin
        if (bus.fifo_opcode == 2'b01 && env_q.size() < DEPTH) env_q.push_back(bus.fifo_din);
        else if (bus.fifo_opcode == 2'b10 && env_q.size() > 0) void'(env_q.pop_front());
        bus.fifo_dout  <= (env_q.size() > 0) ? env_q[0] : '0;
        bus.fifo_full  <= (env_q.size() == DEPTH);
        bus.fifo_empty <= (env_q.size() == 0);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops expected opcodes and responses whenever the DUT presents them
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.fifo_opcode != 2'b00) begin
                if (op_q.size() == 0) check("unexpected_opcode", {30'd0, bus.fifo_opcode}, 32'd0);
                else begin
                    mo = op_q.pop_front();
                    check("opcode", {30'd0, bus.fifo_opcode}, {30'd0, mo.op});
                    if (mo.chk_din) check("fifo_din", bus.fifo_din, mo.din);
                end
            end
            if (bus.ack_a || bus.ack_b) begin
                check("ack_onehot", {31'd0, bus.ack_a & bus.ack_b}, 32'd0);
                check("busy_in_done", {31'd0, bus.busy}, 32'd1);
                if (resp_q.size() == 0) check("unexpected_ack", {30'd0, bus.ack_b, bus.ack_a}, 32'd0);
                else begin
                    mr = resp_q.pop_front();
                    check("ack_port", {31'd0, bus.ack_b}, {31'd0, mr.port_b});
                    check("err", {31'd0, mr.port_b ? bus.err_b : bus.err_a}, {31'd0, mr.err});
                    if (mr.rd) check("rd_data", bus.rd_data, mr.data);
                    check("latency_cycle", cyc, mr.cyc);
                end
            end
        end
    end

    // One arbitration round: predicts service order and outcomes, then drives the requests
    task automatic round(bit ra, bit rb, bit wa, bit wb, logic [31:0] da, logic [31:0] db);
        int          t;
        int          exp_c;
        bit          first_b, pb, w, acc;
        logic [31:0] d;
        resp_t       r;
        @(negedge clk);
        exp_c   = cyc;
        first_b = (ra && rb) ? !model_last_b : rb;
        for (int k = 0; k < int'(ra) + int'(rb); k++) begin
            pb  = (k == 0) ? first_b : !first_b;
            w   = pb ? wb : wa;
            d   = pb ? db : da;
            acc = w ? (model_q.size() < DEPTH) : (model_q.size() > 0);
            r.port_b = pb;
            r.err    = !acc;
            r.rd     = acc && !w;
            r.data   = '0;
            if (acc && w) begin
                model_q.push_back(d);
                op_q.push_back('{2'b01, d, 1'b1});
            end else if (acc) begin
                r.data = model_q.pop_front();
                op_q.push_back('{2'b10, 32'd0, 1'b0});
            end
            exp_c += ((k == 0) ? 0 : 1) + (acc ? 2 : 1);
            r.cyc = exp_c;
            model_last_b = pb;
            resp_q.push_back(r);
        end
        bus.req_a = ra; bus.wr_a = wa; bus.din_a = da;
        bus.req_b = rb; bus.wr_b = wb; bus.din_b = db;
        t = 0;
        while ((bus.req_a || bus.req_b) && t < 20) begin
            @(negedge clk);
            t++;
            if (bus.ack_a) bus.req_a = 1'b0;
            if (bus.ack_b) bus.req_b = 1'b0;
        end
        if (t >= 20) begin
            total++;
            $display("FAIL ack_timeout: got no ack after %0d cycles required within 20", t);
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        bit ra, rb;
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.wr_a = 1'b0; bus.wr_b = 1'b0;
        bus.din_a = '0;   bus.din_b = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ack_a", {31'd0, bus.ack_a}, 32'd0);
        check("rst_ack_b", {31'd0, bus.ack_b}, 32'd0);
        check("rst_err", {30'd0, bus.err_a, bus.err_b}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_opcode", {30'd0, bus.fifo_opcode}, 32'd0);
        check("rst_fifo_din", bus.fifo_din, 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("idle_busy", {31'd0, bus.busy}, 32'd0);
        end
        round(0, 1, 0, 0, 32'd0, 32'd0);
        round(1, 1, 1, 1, 32'hA5A5_0001, 32'hB0B0_0002);
        round(1, 1, 1, 1, 32'hA5A5_0003, 32'hB0B0_0004);
        round(1, 0, 1, 0, 32'hDEAD_BEEF, 32'd0);
        repeat (4) round(0, 1, 0, 0, 32'd0, 32'd0);
        round(1, 0, 1, 0, 32'h1111_2222, 32'd0);
        round(0, 1, 0, 0, 32'd0, 32'd0);
        round(0, 1, 1, 1, 32'd0, 32'h3333_4444);
        @(negedge clk);
        bus.req_a = 1'b1; bus.wr_a = 1'b1; bus.din_a = 32'h5555_6666;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_opcode", {30'd0, bus.fifo_opcode}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_rd_data", bus.rd_data, 32'd0);
        check("abort_fifo_din", bus.fifo_din, 32'd0);
        bus.req_a = 1'b0;
        model_last_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        round(1, 1, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 60; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            round(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        repeat (4) @(negedge clk);
        check("resp_queue_drained", resp_q.size(), 32'd0);
        check("op_queue_drained", op_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
